// File: rtl/alien_pkg.sv
// Shared definitions for the alien table controller.
//   - Default geometry/width constants used as parameter defaults.
//   - Command opcodes carried on cmd_op.
//   - Controller state encoding and sweep update modes.
package alien_pkg;

  // Default table geometry and record field widths.
  localparam int unsigned DEF_NUM_ALIENS = 18;
  localparam int unsigned DEF_ALIEN_COLS = 6;
  localparam int unsigned DEF_X_W        = 10;
  localparam int unsigned DEF_Y_W        = 10;
  localparam int unsigned DEF_EXPL_W     = 5;
  localparam int unsigned DEF_D_W        = 4;
  localparam int unsigned TYPE_W         = 2;

  // Command opcodes.
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_KILL  = 2'b01;
  localparam logic [1:0] OP_MOVE  = 2'b10;
  localparam logic [1:0] OP_TICK  = 2'b11;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    SWEEP = 2'd2
  } state_e;

  // Per-entry update applied by the sweep datapath.
  typedef enum logic [1:0] {
    UPD_INIT = 2'd0,
    UPD_MOVE = 2'd1,
    UPD_TICK = 2'd2
  } upd_mode_e;

endpackage

// File: rtl/alien_entry_update.sv
// Combinational next-record function for one table entry during a sweep.
// Record layout, MSB to LSB: {x, y, type, alive, expl}.
// Ports:
//   mode_i  update kind (UPD_INIT / UPD_MOVE / UPD_TICK)
//   idx_i   entry index, used only to place the entry in the formation
//   rec_i   current record
//   dx_i    signed x offset for MOVE
//   dy_i    signed y offset for MOVE
//   rec_o   next record
module alien_entry_update
  import alien_pkg::*;
#(
  parameter int unsigned IDX_W      = 5,
  parameter int unsigned ALIEN_COLS = DEF_ALIEN_COLS,
  parameter int unsigned X_W        = DEF_X_W,
  parameter int unsigned Y_W        = DEF_Y_W,
  parameter int unsigned EXPL_W     = DEF_EXPL_W,
  parameter int unsigned D_W        = DEF_D_W,
  parameter int unsigned X0         = 50,
  parameter int unsigned Y0         = 50,
  parameter int unsigned X_SP       = 40,
  parameter int unsigned Y_SP       = 35,
  localparam int unsigned WORD_W    = X_W + Y_W + TYPE_W + 1 + EXPL_W
) (
  input  logic [1:0]        mode_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] rec_i,
  input  logic [D_W-1:0]    dx_i,
  input  logic [D_W-1:0]    dy_i,
  output logic [WORD_W-1:0] rec_o
);

  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [TYPE_W-1:0] typ;
  logic              alive;
  logic [EXPL_W-1:0] expl;

  assign {x, y, typ, alive, expl} = rec_i;

  // Formation placement for INIT.
  int unsigned col;
  int unsigned row;
  logic [TYPE_W-1:0] init_type;

  assign col       = 32'(idx_i) % ALIEN_COLS;
  assign row       = 32'(idx_i) / ALIEN_COLS;
  assign init_type = (row > 3) ? TYPE_W'(3) : TYPE_W'(row);

  // Two guard bits above the field: the top one flags an underflow below 0,
  // the next one an overflow past the field maximum.
  logic [X_W+1:0] sum_x;
  logic [Y_W+1:0] sum_y;
  logic [X_W-1:0] sat_x;
  logic [Y_W-1:0] sat_y;

  assign sum_x = {2'b00, x} + {{(X_W+2-D_W){dx_i[D_W-1]}}, dx_i};
  assign sum_y = {2'b00, y} + {{(Y_W+2-D_W){dy_i[D_W-1]}}, dy_i};

  assign sat_x = sum_x[X_W+1] ? '0 : (sum_x[X_W] ? '1 : sum_x[X_W-1:0]);
  assign sat_y = sum_y[Y_W+1] ? '0 : (sum_y[Y_W] ? '1 : sum_y[Y_W-1:0]);

  always_comb begin
    rec_o = rec_i;
    case (mode_i)
      UPD_INIT: rec_o = {X_W'(X0 + col * X_SP), Y_W'(Y0 + row * Y_SP),
                         init_type, 1'b1, {EXPL_W{1'b0}}};
      UPD_MOVE: if (alive) rec_o = {sat_x, sat_y, typ, alive, expl};
      UPD_TICK: if (expl != '0) rec_o = {x, y, typ, alive, expl - EXPL_W'(1)};
      default:  rec_o = rec_i;
    endcase
  end

endmodule

// File: rtl/alien_table_ctrl.sv
// Alien record table with a valid/ready command port and two registered
// read ports. Single-entry WRITE/KILL complete in one cycle; INIT, MOVE and
// TICK sweep the whole table one entry per cycle and refresh the x-bounds
// of living aliens used by the formation-march edge detection.
// Ports:
//   game_clk, reset            clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_op/addr/data/dx/dy     command opcode, target, record, MOVE offsets
//   game_rd_addr/game_rd_data  game read port, 1-cycle latency
//   disp_addr/disp_data        display read port, 1-cycle latency
//   busy, done                 sweep in progress / completion pulse
//   alive_count                number of alive entries
//   min_x, max_x, bounds_valid x-bounds of alive entries at the last sweep
module alien_table_ctrl
  import alien_pkg::*;
#(
  parameter int unsigned NUM_ALIENS = DEF_NUM_ALIENS,
  parameter int unsigned ALIEN_COLS = DEF_ALIEN_COLS,
  parameter int unsigned X_W        = DEF_X_W,
  parameter int unsigned Y_W        = DEF_Y_W,
  parameter int unsigned EXPL_W     = DEF_EXPL_W,
  parameter logic [EXPL_W-1:0] EXPL_INIT = 5'd20,
  parameter int unsigned X0         = 50,
  parameter int unsigned Y0         = 50,
  parameter int unsigned X_SP       = 40,
  parameter int unsigned Y_SP       = 35,
  parameter int unsigned D_W        = DEF_D_W,
  localparam int unsigned AW        = $clog2(NUM_ALIENS),
  localparam int unsigned WORD_W    = X_W + Y_W + TYPE_W + 1 + EXPL_W
) (
  input  logic              game_clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [WORD_W-1:0] cmd_data,
  input  logic [D_W-1:0]    cmd_dx,
  input  logic [D_W-1:0]    cmd_dy,
  input  logic [AW-1:0]     game_rd_addr,
  output logic [WORD_W-1:0] game_rd_data,
  input  logic [AW-1:0]     disp_addr,
  output logic [WORD_W-1:0] disp_data,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       alive_count,
  output logic [X_W-1:0]    min_x,
  output logic [X_W-1:0]    max_x,
  output logic              bounds_valid
);

  localparam int unsigned ALIVE_BIT = EXPL_W;
  localparam int unsigned X_LSB     = WORD_W - X_W;
  localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_ALIENS - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(NUM_ALIENS);

  // Record table and controller state.
  logic [WORD_W-1:0] table_q [NUM_ALIENS];

  state_e            state_q;
  logic [AW-1:0]     idx_q;
  logic [1:0]        op_q;
  logic [D_W-1:0]    dx_q, dy_q;
  logic              cmd_ready_q, busy_q, done_q;
  logic [AW:0]       alive_count_q, alive_count_d;
  logic [X_W-1:0]    min_x_q, max_x_q;
  logic              bounds_valid_q;
  logic              acc_any_q;
  logic [X_W-1:0]    acc_min_q, acc_max_q;
  logic [WORD_W-1:0] game_rd_data_q, disp_data_q;

  // Sweep datapath: one entry read, updated and written back per cycle.
  logic [1:0]        upd_mode;
  logic [WORD_W-1:0] upd_rec;
  logic              upd_alive;
  logic [X_W-1:0]    upd_x;

  assign upd_mode = (state_q == INIT) ? UPD_INIT :
                    (op_q == OP_MOVE) ? UPD_MOVE : UPD_TICK;

  alien_entry_update #(
    .IDX_W      (AW),
    .ALIEN_COLS (ALIEN_COLS),
    .X_W        (X_W),
    .Y_W        (Y_W),
    .EXPL_W     (EXPL_W),
    .D_W        (D_W),
    .X0         (X0),
    .Y0         (Y0),
    .X_SP       (X_SP),
    .Y_SP       (Y_SP)
  ) u_entry_update (
    .mode_i (upd_mode),
    .idx_i  (idx_q),
    .rec_i  (table_q[idx_q]),
    .dx_i   (dx_q),
    .dy_i   (dy_q),
    .rec_o  (upd_rec)
  );

  assign upd_alive = upd_rec[ALIVE_BIT];
  assign upd_x     = upd_rec[X_LSB +: X_W];

  // Running x-bounds over post-update alive entries; entry 0 starts afresh.
  logic           base_any, acc_any_d;
  logic [X_W-1:0] base_min, base_max, acc_min_d, acc_max_d;

  always_comb begin
    // NOTE: every always_comb output is given a default first so no path
    // leaves it unassigned and infers a latch.
    base_any  = (idx_q == '0) ? 1'b0 : acc_any_q;
    base_min  = base_any ? acc_min_q : '0;
    base_max  = base_any ? acc_max_q : '0;
    acc_any_d = base_any | upd_alive;
    acc_min_d = base_min;
    acc_max_d = base_max;
    if (upd_alive) begin
      if (!base_any || upd_x < base_min) acc_min_d = upd_x;
      if (!base_any || upd_x > base_max) acc_max_d = upd_x;
    end
  end

  // Command decode and table write port.
  logic              cmd_accept, cmd_in_range, cmd_old_alive;
  logic [AW-1:0]     cmd_idx;
  logic              tbl_we;
  logic [AW-1:0]     tbl_waddr;
  logic [WORD_W-1:0] tbl_wdata;

  assign cmd_accept    = cmd_valid & cmd_ready_q;
  assign cmd_in_range  = 32'(cmd_addr) < NUM_ALIENS;
  assign cmd_idx       = cmd_in_range ? cmd_addr : '0;
  assign cmd_old_alive = table_q[cmd_idx][ALIVE_BIT];

  always_comb begin
    tbl_we        = 1'b0;
    tbl_waddr     = idx_q;
    tbl_wdata     = upd_rec;
    alive_count_d = alive_count_q;
    if (state_q != IDLE) begin
      tbl_we = 1'b1;
    end else if (cmd_accept && cmd_in_range) begin
      tbl_waddr = cmd_addr;
      if (cmd_op == OP_WRITE) begin
        tbl_we    = 1'b1;
        tbl_wdata = cmd_data;
        if (cmd_data[ALIVE_BIT] && !cmd_old_alive)
          alive_count_d = alive_count_q + (AW+1)'(1);
        else if (!cmd_data[ALIVE_BIT] && cmd_old_alive)
          alive_count_d = alive_count_q - (AW+1)'(1);
      end else if (cmd_op == OP_KILL && cmd_old_alive) begin
        tbl_we        = 1'b1;
        tbl_wdata     = {table_q[cmd_idx][WORD_W-1:ALIVE_BIT+1], 1'b0, EXPL_INIT};
        alive_count_d = alive_count_q - (AW+1)'(1);
      end
    end
  end

  // NOTE: the table has no reset; INIT rewrites every entry after reset, so
  // clearing it here would only add reset fan-out to a large flop array.
  always_ff @(posedge game_clk) begin
    if (tbl_we) table_q[tbl_waddr] <= tbl_wdata;
  end

  logic game_in_range, disp_in_range;
  assign game_in_range = 32'(game_rd_addr) < NUM_ALIENS;
  assign disp_in_range = 32'(disp_addr) < NUM_ALIENS;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, which also gives read-old-on-write for free.
  always_ff @(posedge game_clk or posedge reset) begin
    if (reset) begin
      state_q        <= INIT;
      idx_q          <= '0;
      op_q           <= OP_WRITE;
      dx_q           <= '0;
      dy_q           <= '0;
      cmd_ready_q    <= 1'b0;
      busy_q         <= 1'b1;
      done_q         <= 1'b0;
      alive_count_q  <= '0;
      min_x_q        <= '0;
      max_x_q        <= '0;
      bounds_valid_q <= 1'b0;
      acc_any_q      <= 1'b0;
      acc_min_q      <= '0;
      acc_max_q      <= '0;
      game_rd_data_q <= '0;
      disp_data_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        INIT, SWEEP: begin
          acc_any_q <= acc_any_d;
          acc_min_q <= acc_min_d;
          acc_max_q <= acc_max_d;
          idx_q     <= idx_q + AW'(1);
          if (idx_q == LAST_IDX) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            cmd_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b1;
            min_x_q        <= acc_min_d;
            max_x_q        <= acc_max_d;
            bounds_valid_q <= acc_any_d;
            if (state_q == INIT) alive_count_q <= FULL_COUNT;
          end
        end
        IDLE: begin
          if (cmd_accept) begin
            if (cmd_op == OP_WRITE || cmd_op == OP_KILL) begin
              done_q        <= 1'b1;
              alive_count_q <= alive_count_d;
            end else begin
              state_q     <= SWEEP;
              op_q        <= cmd_op;
              dx_q        <= cmd_dx;
              dy_q        <= cmd_dy;
              idx_q       <= '0;
              cmd_ready_q <= 1'b0;
              busy_q      <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
      game_rd_data_q <= game_in_range ? table_q[game_rd_addr] : '0;
      disp_data_q    <= disp_in_range ? table_q[disp_addr] : '0;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign alive_count  = alive_count_q;
  assign min_x        = min_x_q;
  assign max_x        = max_x_q;
  assign bounds_valid = bounds_valid_q;
  assign game_rd_data = game_rd_data_q;
  assign disp_data    = disp_data_q;

endmodule

// File: tb/tb_alien_table_ctrl.sv
// Directed self-checking bench for alien_table_ctrl at default parameters.
module tb_alien_table_ctrl;
  import alien_pkg::*;

  logic        game_clk = 1'b0;
  logic        reset    = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op   = 2'b00;
  logic [4:0]  cmd_addr = '0;
  logic [27:0] cmd_data = '0;
  logic [3:0]  cmd_dx   = '0;
  logic [3:0]  cmd_dy   = '0;
  logic [4:0]  game_rd_addr = '0;
  logic [27:0] game_rd_data;
  logic [4:0]  disp_addr = '0;
  logic [27:0] disp_data;
  logic        busy, done;
  logic [5:0]  alive_count;
  logic [9:0]  min_x, max_x;
  logic        bounds_valid;

  alien_table_ctrl dut (
    .game_clk     (game_clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .cmd_dx       (cmd_dx),
    .cmd_dy       (cmd_dy),
    .game_rd_addr (game_rd_addr),
    .game_rd_data (game_rd_data),
    .disp_addr    (disp_addr),
    .disp_data    (disp_data),
    .busy         (busy),
    .done         (done),
    .alive_count  (alive_count),
    .min_x        (min_x),
    .max_x        (max_x),
    .bounds_valid (bounds_valid)
  );

  always #5 game_clk = ~game_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] mk(input int x, input int y, input int t,
                                     input int a, input int e);
    return {10'(x), 10'(y), 2'(t), 1'(a), 5'(e)};
  endfunction

  task automatic tick();
    @(posedge game_clk);
    #1;
  endtask

  task automatic read_game(input logic [4:0] a, output logic [27:0] d);
    game_rd_addr = a;
    tick();
    d = game_rd_data;
  endtask

  // Presents a command once ready is high; returns just after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [4:0] a,
                       input logic [27:0] d, input logic [3:0] dx, input logic [3:0] dy);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("ready_wait", 32'(cmd_ready), 32'd1);
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_dx    = dx;
    cmd_dy    = dy;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Cycles after the current sample until done is seen (100 means timeout).
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [4:0] a,
                        input logic [27:0] d, input logic [3:0] dx,
                        input logic [3:0] dy, output int n);
    issue(op, a, d, dx, dy);
    wait_done(n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [27:0] r;

    // Reset state.
    repeat (3) tick();
    check("rst_ready", 32'(cmd_ready), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_done", 32'(done), 0);
    check("rst_alive", 32'(alive_count), 0);
    check("rst_min", 32'(min_x), 0);
    check("rst_max", 32'(max_x), 0);
    check("rst_bv", 32'(bounds_valid), 0);
    check("rst_game_rd", 32'(game_rd_data), 0);
    check("rst_disp", 32'(disp_data), 0);

    // INIT formation.
    reset = 1'b0;
    wait_done(n);
    check("init_cycles", 32'(n), 18);
    check("init_busy", 32'(busy), 0);
    check("init_ready", 32'(cmd_ready), 1);
    check("init_alive", 32'(alive_count), 18);
    check("init_min", 32'(min_x), 50);
    check("init_max", 32'(max_x), 250);
    check("init_bv", 32'(bounds_valid), 1);
    tick();
    check("init_done_pulse", 32'(done), 0);
    read_game(5'd7, r);
    check("init_e7", 32'(r), 32'(mk(90, 85, 1, 1, 0)));
    read_game(5'd17, r);
    check("init_e17", 32'(r), 32'(mk(250, 120, 2, 1, 0)));

    // KILL, then KILL of a dead entry.
    do_cmd(OP_KILL, 5'd3, '0, '0, '0, n);
    check("kill1_done", 32'(n), 0);
    check("kill1_alive", 32'(alive_count), 17);
    read_game(5'd3, r);
    check("kill1_e3", 32'(r), 32'(mk(170, 50, 0, 0, 20)));
    do_cmd(OP_KILL, 5'd3, '0, '0, '0, n);
    check("kill2_done", 32'(n), 0);
    check("kill2_alive", 32'(alive_count), 17);
    read_game(5'd3, r);
    check("kill2_e3", 32'(r), 32'(mk(170, 50, 0, 0, 20)));
    check("kill_min_hold", 32'(min_x), 50);
    check("kill_max_hold", 32'(max_x), 250);

    // Kill column 0, then MOVE -8/+2 with a command offered mid-sweep.
    do_cmd(OP_KILL, 5'd0, '0, '0, '0, n);
    do_cmd(OP_KILL, 5'd6, '0, '0, '0, n);
    do_cmd(OP_KILL, 5'd12, '0, '0, '0, n);
    check("col0_alive", 32'(alive_count), 14);
    issue(OP_MOVE, 5'd0, '0, 4'h8, 4'h2);
    cmd_op    = OP_WRITE;
    cmd_addr  = 5'd1;
    cmd_data  = mk(999, 999, 3, 0, 0);
    cmd_valid = 1'b1;
    check("sweep_ready", 32'(cmd_ready), 0);
    check("sweep_busy", 32'(busy), 1);
    repeat (3) tick();
    cmd_valid = 1'b0;
    wait_done(n);
    check("move1_cycles", 32'(n), 15);
    check("move1_min", 32'(min_x), 82);
    check("move1_max", 32'(max_x), 242);
    check("move1_bv", 32'(bounds_valid), 1);
    check("move1_alive", 32'(alive_count), 14);
    read_game(5'd0, r);
    check("move1_e0_dead", 32'(r), 32'(mk(50, 50, 0, 0, 20)));
    read_game(5'd1, r);
    check("move1_e1_ignored_cmd", 32'(r), 32'(mk(82, 52, 0, 1, 0)));
    read_game(5'd7, r);
    check("move1_e7", 32'(r), 32'(mk(82, 87, 1, 1, 0)));

    // Saturation at 0 and at the field maximum.
    do_cmd(OP_WRITE, 5'd5, mk(3, 100, 0, 1, 0), '0, '0, n);
    check("wr5_done", 32'(n), 0);
    check("wr5_alive", 32'(alive_count), 14);
    do_cmd(OP_MOVE, 5'd0, '0, 4'h8, 4'h0, n);
    check("move2_cycles", 32'(n), 18);
    read_game(5'd5, r);
    check("move2_sat_lo", 32'(r), 32'(mk(0, 100, 0, 1, 0)));
    check("move2_min", 32'(min_x), 0);
    check("move2_max", 32'(max_x), 234);
    do_cmd(OP_WRITE, 5'd5, mk(1020, 100, 0, 1, 0), '0, '0, n);
    do_cmd(OP_MOVE, 5'd0, '0, 4'h7, 4'h0, n);
    read_game(5'd5, r);
    check("move3_sat_hi", 32'(r), 32'(mk(1023, 100, 0, 1, 0)));
    check("move3_min", 32'(min_x), 81);
    check("move3_max", 32'(max_x), 1023);

    // TICK.
    do_cmd(OP_TICK, 5'd0, '0, '0, '0, n);
    check("tick_cycles", 32'(n), 18);
    read_game(5'd3, r);
    check("tick_e3", 32'(r), 32'(mk(170, 50, 0, 0, 19)));
    read_game(5'd0, r);
    check("tick_e0", 32'(r), 32'(mk(50, 50, 0, 0, 19)));
    read_game(5'd7, r);
    check("tick_e7_untouched", 32'(r), 32'(mk(81, 87, 1, 1, 0)));
    check("tick_alive", 32'(alive_count), 14);
    check("tick_min", 32'(min_x), 81);
    check("tick_max", 32'(max_x), 1023);

    // WRITE changing alive, out-of-range commands.
    do_cmd(OP_WRITE, 5'd3, mk(400, 60, 2, 1, 0), '0, '0, n);
    check("wr3_alive_up", 32'(alive_count), 15);
    do_cmd(OP_WRITE, 5'd4, mk(0, 0, 0, 0, 0), '0, '0, n);
    check("wr4_alive_down", 32'(alive_count), 14);
    check("wr_min_hold", 32'(min_x), 81);
    check("wr_max_hold", 32'(max_x), 1023);
    do_cmd(OP_WRITE, 5'd20, mk(1, 1, 1, 1, 1), '0, '0, n);
    check("wr_oor_done", 32'(n), 0);
    check("wr_oor_alive", 32'(alive_count), 14);
    do_cmd(OP_KILL, 5'd25, '0, '0, '0, n);
    check("kill_oor_done", 32'(n), 0);
    check("kill_oor_alive", 32'(alive_count), 14);

    // Read-during-write on the display port returns the old record.
    disp_addr = 5'd3;
    issue(OP_WRITE, 5'd3, mk(11, 22, 3, 1, 5), '0, '0);
    check("rdw_old", 32'(disp_data), 32'(mk(400, 60, 2, 1, 0)));
    tick();
    check("rdw_new", 32'(disp_data), 32'(mk(11, 22, 3, 1, 5)));
    disp_addr = 5'd20;
    tick();
    check("disp_oor", 32'(disp_data), 0);
    read_game(5'd31, r);
    check("game_oor", 32'(r), 0);

    // Reset in the middle of a MOVE sweep.
    issue(OP_MOVE, 5'd0, '0, 4'h1, 4'h0);
    repeat (9) tick();
    reset = 1'b1;
    #1;
    check("midrst_ready", 32'(cmd_ready), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_busy", 32'(busy), 1);
    check("midrst_alive", 32'(alive_count), 0);
    check("midrst_bv", 32'(bounds_valid), 0);
    tick();
    reset = 1'b0;
    wait_done(n);
    check("reinit_cycles", 32'(n), 18);
    check("reinit_alive", 32'(alive_count), 18);
    check("reinit_min", 32'(min_x), 50);
    check("reinit_max", 32'(max_x), 250);
    read_game(5'd0, r);
    check("reinit_e0", 32'(r), 32'(mk(50, 50, 0, 1, 0)));
    read_game(5'd3, r);
    check("reinit_e3", 32'(r), 32'(mk(170, 50, 0, 1, 0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
